// File: rtl/led_pkg.sv
// Shared types and constants for the WS2812B frame driver.
package led_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StLatch
  } led_state_e;

  localparam int unsigned GRB_W          = 24;
  localparam int unsigned NUM_PIX        = 64;
  localparam int unsigned BITS_PER_FRAME = NUM_PIX * GRB_W;

  // Default timing at 12 MHz.
  localparam int unsigned T0H_DEF             = 4;
  localparam int unsigned T1H_DEF             = 8;
  localparam int unsigned TBIT_DEF            = 15;
  localparam int unsigned LATCH_DEF           = 600;
  localparam int unsigned FRAMES_PER_STEP_DEF = 30;

  localparam logic [GRB_W-1:0] ALIVE_DEF = 24'h001000;
  localparam logic [GRB_W-1:0] DEAD_DEF  = 24'h000000;

  // Counter width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/led_frame_driver_if.sv
// Rules-stage facing signals plus the LED data pin of the frame driver.
interface led_frame_driver_if;
  logic        enable;
  logic [63:0] grid;
  logic        dout;
  logic        step;
  logic        busy;
  logic        frame_done;

  // Rules stage / environment side.
  modport master (
    output enable,
    output grid,
    input  dout,
    input  step,
    input  busy,
    input  frame_done
  );

  // Frame driver side.
  modport slave (
    input  enable,
    input  grid,
    output dout,
    output step,
    output busy,
    output frame_done
  );
endinterface

// File: rtl/ws2812_bit_tx.sv
// Single WS2812B bit transmitter: a start pulse launches one bit period whose
// high time depends on bit_val. bit_done flags the final cycle of the period so
// the next bit can be chained without a gap.
module ws2812_bit_tx
  import led_pkg::*;
#(
  parameter int unsigned T0H_CYC  = T0H_DEF,
  parameter int unsigned T1H_CYC  = T1H_DEF,
  parameter int unsigned TBIT_CYC = TBIT_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic bit_val,
  output logic dout,
  output logic bit_done
);

  localparam int unsigned CycW = clog2_min1(TBIT_CYC);
  localparam logic [CycW-1:0] T0H     = CycW'(T0H_CYC);
  localparam logic [CycW-1:0] T1H     = CycW'(T1H_CYC);
  localparam logic [CycW-1:0] CycLast = CycW'(TBIT_CYC - 1);

  logic [CycW-1:0] cyc_q, cyc_d, cyc_nxt;
  logic [CycW-1:0] th_q, th_d;
  logic            active_q, active_d;
  logic            dout_q, dout_d;

  assign bit_done = active_q && (cyc_q == CycLast);
  assign dout     = dout_q;
  assign cyc_nxt  = cyc_q + CycW'(1);

  // Next-state: restart on start, otherwise walk the bit period.
  always_comb begin
    cyc_d    = cyc_q;
    th_d     = th_q;
    active_d = active_q;
    dout_d   = dout_q;
    if (start) begin
      active_d = 1'b1;
      cyc_d    = '0;
      th_d     = bit_val ? T1H : T0H;
      dout_d   = 1'b1;
    end else if (active_q) begin
      if (bit_done) begin
        active_d = 1'b0;
        cyc_d    = '0;
        dout_d   = 1'b0;
      end else begin
        cyc_d  = cyc_nxt;
        dout_d = (cyc_nxt < th_q);
      end
    end
  end

  // State register; dout is registered so it drops asynchronously on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q    <= '0;
      th_q     <= '0;
      active_q <= 1'b0;
      dout_q   <= 1'b0;
    end else begin
      cyc_q    <= cyc_d;
      th_q     <= th_d;
      active_q <= active_d;
      dout_q   <= dout_d;
    end
  end

endmodule

// File: rtl/led_frame_driver.sv
// Snapshots the 8x8 Life grid, streams it to a WS2812B matrix, and pulses
// step every FRAMES_PER_STEP frames to advance the rules stage.
// Build option SERPENTINE_EN: odd rows are sent in reverse column order.
module led_frame_driver
  import led_pkg::*;
#(
  parameter int unsigned       T0H_CYC         = T0H_DEF,
  parameter int unsigned       T1H_CYC         = T1H_DEF,
  parameter int unsigned       TBIT_CYC        = TBIT_DEF,
  parameter int unsigned       LATCH_CYC       = LATCH_DEF,
  parameter int unsigned       FRAMES_PER_STEP = FRAMES_PER_STEP_DEF,
  parameter logic [GRB_W-1:0]  ALIVE_GRB       = ALIVE_DEF,
  parameter logic [GRB_W-1:0]  DEAD_GRB        = DEAD_DEF
) (
  input logic              clk,
  input logic              reset_n,
  led_frame_driver_if.slave bus
);

  localparam int unsigned CycW = clog2_min1((TBIT_CYC > LATCH_CYC) ? TBIT_CYC : LATCH_CYC);
  localparam int unsigned FcW  = clog2_min1(FRAMES_PER_STEP + 1);
  localparam logic [CycW-1:0] LatchLast = CycW'(LATCH_CYC - 1);
  localparam logic [FcW-1:0]  FcLast    = FcW'(FRAMES_PER_STEP - 1);
  localparam logic [5:0]      PixLast   = 6'(NUM_PIX - 1);
  localparam logic [4:0]      BitMsb    = 5'(GRB_W - 1);

  // Maps transmit order to grid bit index.
  function automatic logic [5:0] pix_to_idx(input logic [5:0] pix);
`ifdef SERPENTINE_EN
    return {pix[5:3], pix[2:0] ^ {3{pix[3]}}};
`else
    return pix;
`endif
  endfunction

  led_state_e       state_q, state_d;
  logic [63:0]      snap_q, snap_d;
  logic [5:0]       pix_q, pix_d, nxt_pix;
  logic [4:0]       bit_q, bit_d, nxt_bit;
  logic [CycW-1:0]  lcyc_q, lcyc_d;
  logic [FcW-1:0]   fc_q, fc_d;
  logic             busy_q;
  logic [63:0]      src;
  logic [GRB_W-1:0] colour;
  logic             last_bit;
  logic             tx_start, tx_bit_val, tx_bit_done, tx_dout;
  logic             step_pulse, done_pulse;

  assign last_bit = (pix_q == PixLast) && (bit_q == '0);

  // Select the bit that the next tx_start will launch. In IDLE the first bit
  // comes straight from grid because the snapshot loads on the same edge.
  always_comb begin
    if (state_q == StShift) begin
      nxt_bit = (bit_q == '0) ? BitMsb : bit_q - 5'd1;
      nxt_pix = (bit_q == '0) ? pix_q + 6'd1 : pix_q;
      src     = snap_q;
    end else begin
      nxt_bit = BitMsb;
      nxt_pix = '0;
      src     = bus.grid;
    end
    colour     = src[pix_to_idx(nxt_pix)] ? ALIVE_GRB : DEAD_GRB;
    tx_bit_val = colour[nxt_bit];
  end

  // Frame sequencing: next state, counters and the end-of-latch pulses.
  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    pix_d      = pix_q;
    bit_d      = bit_q;
    lcyc_d     = lcyc_q;
    fc_d       = fc_q;
    tx_start   = 1'b0;
    done_pulse = 1'b0;
    step_pulse = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.enable) begin
          state_d  = StShift;
          snap_d   = bus.grid;
          pix_d    = '0;
          bit_d    = BitMsb;
          tx_start = 1'b1;
        end
      end
      StShift: begin
        if (tx_bit_done) begin
          if (last_bit) begin
            state_d = StLatch;
            lcyc_d  = '0;
          end else begin
            tx_start = 1'b1;
            pix_d    = nxt_pix;
            bit_d    = nxt_bit;
          end
        end
      end
      StLatch: begin
        if (lcyc_q == LatchLast) begin
          done_pulse = 1'b1;
          state_d    = StIdle;
          if (fc_q == FcLast) begin
            step_pulse = 1'b1;
            fc_d       = '0;
          end else begin
            fc_d = fc_q + FcW'(1);
          end
        end else begin
          lcyc_d = lcyc_q + CycW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      snap_q  <= '0;
      pix_q   <= '0;
      bit_q   <= '0;
      lcyc_q  <= '0;
      fc_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      pix_q   <= pix_d;
      bit_q   <= bit_d;
      lcyc_q  <= lcyc_d;
      fc_q    <= fc_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  ws2812_bit_tx #(
    .T0H_CYC  (T0H_CYC),
    .T1H_CYC  (T1H_CYC),
    .TBIT_CYC (TBIT_CYC)
  ) u_bit_tx (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (tx_start),
    .bit_val  (tx_bit_val),
    .dout     (tx_dout),
    .bit_done (tx_bit_done)
  );

  assign bus.dout       = tx_dout;
  assign bus.busy       = busy_q;
  assign bus.step       = step_pulse;
  assign bus.frame_done = done_pulse;

endmodule

// File: tb/tb_led_frame_driver.sv
// Bench for led_frame_driver: decodes the dout waveform back into pixels and
// compares them with colours derived from the grid and the matrix wiring.
module tb_led_frame_driver;
  import led_pkg::*;

  localparam int unsigned T0H   = 1;
  localparam int unsigned T1H   = 2;
  localparam int unsigned TBIT  = 3;
  localparam int unsigned LATCH = 7;
  localparam int unsigned FPS   = 2;
  localparam logic [23:0] ALIVE = 24'h9C35E1;
  localparam logic [23:0] DEAD  = 24'h01200A;
  localparam int FRAME_CYC = 1536 * TBIT + LATCH;
  localparam int BUDGET    = 2 * FRAME_CYC + 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int model_fc = 0;

  led_frame_driver_if bus();

  led_frame_driver #(
    .T0H_CYC         (T0H),
    .T1H_CYC         (T1H),
    .TBIT_CYC        (TBIT),
    .LATCH_CYC       (LATCH),
    .FRAMES_PER_STEP (FPS),
    .ALIVE_GRB       (ALIVE),
    .DEAD_GRB        (DEAD)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Waveform decoder state.
  bit          mon_bits[$];
  int          mon_cyc = 0, mon_first = 0, mon_len = 0, mon_nbits = 0, mon_frames = 0;
  int          mon_bad = 0, mon_rises = 0, mon_steps = 0, mon_stray = 0, hi_len = 0;
  bit          mon_prev = 0, mon_started = 0, mon_step_at_fd = 0;
  logic [23:0] mon_pix[64];

  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mon_bits.delete();
      hi_len      = 0;
      mon_prev    = 0;
      mon_started = 0;
    end else begin
      mon_cyc++;
      if (bus.dout === 1'b1) begin
        if (!mon_prev) begin
          mon_rises++;
          if (!mon_started) begin
            mon_started = 1;
            mon_first   = mon_cyc;
          end
        end
        hi_len++;
      end else if (mon_prev) begin
        mon_bits.push_back(hi_len == int'(T1H));
        if (hi_len != int'(T0H) && hi_len != int'(T1H)) mon_bad++;
        hi_len = 0;
      end
      mon_prev = (bus.dout === 1'b1);
      if (bus.step === 1'b1) mon_steps++;
      if (bus.step === 1'b1 && bus.frame_done !== 1'b1) mon_stray++;
      if (bus.frame_done === 1'b1) begin
        mon_nbits = mon_bits.size();
        mon_len   = mon_cyc - mon_first + 1;
        for (int p = 0; p < 64; p++) begin
          logic [23:0] v;
          v = '0;
          for (int i = 0; i < 24; i++) begin
            int idx;
            idx = p * 24 + i;
            v = {v[22:0], (idx < mon_bits.size()) ? mon_bits[idx] : 1'b0};
          end
          mon_pix[p] = v;
        end
        mon_step_at_fd = (bus.step === 1'b1);
        mon_bits.delete();
        mon_started = 0;
        mon_frames++;
      end
    end
  end

  // Expected colour of the p-th transmitted pixel.
  function automatic logic [23:0] exp_pix(input logic [63:0] g, input int p);
    int row, col;
    row = p / 8;
    col = p % 8;
`ifdef SERPENTINE_EN
    if (row % 2 == 1) col = 7 - col;
`endif
    return g[row * 8 + col] ? ALIVE : DEAD;
  endfunction

  function automatic int count_bad(input logic [63:0] g);
    int n;
    n = 0;
    for (int p = 0; p < 64; p++) if (mon_pix[p] !== exp_pix(g, p)) n++;
    return n;
  endfunction

  function automatic bit model_frame_step();
    model_fc = (model_fc + 1) % FPS;
    return (model_fc == 0);
  endfunction

  task automatic wait_frame(output bit ok);
    int start;
    start = mon_frames;
    ok = 0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      #1;
      if (mon_frames != start) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_bits(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      #1;
      if (mon_bits.size() >= n) begin
        ok = 1;
        break;
      end
    end
  endtask

  // One frame launched by a single-cycle enable.
  task automatic start_one(input logic [63:0] g);
    @(negedge clk);
    bus.grid   = g;
    bus.enable = 1'b1;
    @(posedge clk);
    #1;
    bus.enable = 1'b0;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    bus.enable = 1'b0;
    bus.grid   = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.dout !== 1'b0) begin errors++; $display("FAIL reset_dout: got %b want 0", bus.dout); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.step !== 1'b0) begin errors++; $display("FAIL reset_step: got %b want 0", bus.step); end
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.frame_done); end
    reset_n  = 1'b1;
    model_fc = 0;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_disabled_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_zero_frame();
    bit ok, es;
    @(negedge clk);
    bus.grid   = '0;
    bus.enable = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.dout !== 1'b1) begin errors++; $display("FAIL first_dout_latency: got %b want 1", bus.dout); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_in_shift: got %b want 1", bus.busy); end
    bus.enable = 1'b0;
    wait_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL zero_frame_timeout: got no frame_done want one within %0d", BUDGET); end
    es = model_frame_step();
    checks++; if (count_bad(64'h0) != 0) begin errors++; $display("FAIL zero_frame_pixels: got %0d bad pixels want 0", count_bad(64'h0)); end
    checks++; if (mon_nbits != 1536) begin errors++; $display("FAIL zero_frame_bits: got %0d want 1536", mon_nbits); end
    checks++; if (mon_len != FRAME_CYC) begin errors++; $display("FAIL frame_length: got %0d want %0d", mon_len, FRAME_CYC); end
    checks++; if (mon_bad != 0) begin errors++; $display("FAIL pulse_widths: got %0d bad pulses want 0", mon_bad); end
    checks++; if (mon_step_at_fd !== es) begin errors++; $display("FAIL zero_frame_step: got %b want %b", mon_step_at_fd, es); end
    @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_after_latch: got %b want 0", bus.busy); end
  endtask

  task automatic test_single_cell();
    bit ok, es;
    start_one(64'h1);
    wait_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got no frame_done want one"); end
    es = model_frame_step();
    checks++; if (mon_pix[0] !== ALIVE) begin errors++; $display("FAIL single_pix0: got %h want %h", mon_pix[0], ALIVE); end
    checks++; if (count_bad(64'h1) != 0) begin errors++; $display("FAIL single_pixels: got %0d bad want 0", count_bad(64'h1)); end
    checks++; if (mon_step_at_fd !== es) begin errors++; $display("FAIL single_step: got %b want %b", mon_step_at_fd, es); end
  endtask

  task automatic test_random_frames();
    bit ok, es;
    logic [63:0] g;
    for (int n = 0; n < 2; n++) begin
      g = {$urandom, $urandom};
      start_one(g);
      wait_frame(ok);
      checks++; if (!ok) begin errors++; $display("FAIL random_timeout: frame %0d got none want one", n); end
      es = model_frame_step();
      checks++; if (count_bad(g) != 0) begin errors++; $display("FAIL random_pixels: grid %h got %0d bad want 0", g, count_bad(g)); end
      checks++; if (mon_step_at_fd !== es) begin errors++; $display("FAIL random_step: got %b want %b", mon_step_at_fd, es); end
    end
  endtask

  task automatic test_step();
    bit ok, es;
    logic [63:0] g;
    g = {$urandom, $urandom};
    @(negedge clk);
    bus.grid   = g;
    bus.enable = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wait_frame(ok);
      checks++; if (!ok) begin errors++; $display("FAIL step_timeout: frame %0d got none want one", f); end
      es = model_frame_step();
      checks++; if (count_bad(g) != 0) begin errors++; $display("FAIL step_pixels: frame %0d got %0d bad want 0", f, count_bad(g)); end
      checks++; if (mon_step_at_fd !== es) begin errors++; $display("FAIL step_pulse: frame %0d got %b want %b", f, mon_step_at_fd, es); end
      if (f == 3) bus.enable = 1'b0;
      if (es) begin
        g = {$urandom, $urandom};
        bus.grid = g;
      end
      @(posedge clk);
      #1;
      checks++; if (bus.step !== 1'b0) begin errors++; $display("FAIL step_width: got %b want 0", bus.step); end
    end
  endtask

  task automatic test_no_tearing();
    bit ok, es;
    @(negedge clk);
    bus.grid   = '0;
    bus.enable = 1'b1;
    wait_bits(240, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tear_wait: got no pixel 10 want it"); end
    bus.grid = '1;
    wait_frame(ok);
    es = model_frame_step();
    checks++; if (count_bad(64'h0) != 0) begin errors++; $display("FAIL tear_old_frame: got %0d bad want 0", count_bad(64'h0)); end
    checks++; if (mon_step_at_fd !== es) begin errors++; $display("FAIL tear_step0: got %b want %b", mon_step_at_fd, es); end
    wait_frame(ok);
    bus.enable = 1'b0;
    es = model_frame_step();
    checks++; if (count_bad('1) != 0) begin errors++; $display("FAIL tear_new_frame: got %0d bad want 0", count_bad('1)); end
    checks++; if (mon_step_at_fd !== es) begin errors++; $display("FAIL tear_step1: got %b want %b", mon_step_at_fd, es); end
  endtask

  task automatic test_enable_drop();
    bit ok, es;
    logic [63:0] g;
    int rises0, steps0;
    g = {$urandom, $urandom};
    @(negedge clk);
    bus.grid   = g;
    bus.enable = 1'b1;
    wait_bits(30 * 24, ok);
    bus.enable = 1'b0;
    wait_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL drop_timeout: got no frame_done want one"); end
    es = model_frame_step();
    checks++; if (count_bad(g) != 0) begin errors++; $display("FAIL drop_pixels: got %0d bad want 0", count_bad(g)); end
    checks++; if (mon_step_at_fd !== es) begin errors++; $display("FAIL drop_step: got %b want %b", mon_step_at_fd, es); end
    rises0 = mon_rises;
    steps0 = mon_steps;
    repeat (2000) @(negedge clk);
    checks++; if (mon_rises != rises0) begin errors++; $display("FAIL drop_quiet_dout: got %0d rises want 0", mon_rises - rises0); end
    checks++; if (mon_steps != steps0) begin errors++; $display("FAIL drop_quiet_step: got %0d steps want 0", mon_steps - steps0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL drop_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    bit ok, es;
    int p8;
    start_one(64'h100);
    wait_bits(40 * 24, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_wait: got no pixel 40 want it"); end
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.dout !== 1'b0) begin errors++; $display("FAIL rst_mid_dout: got %b want 0", bus.dout); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
    checks++; if (bus.step !== 1'b0) begin errors++; $display("FAIL rst_mid_step: got %b want 0", bus.step); end
    repeat (2) @(negedge clk);
    reset_n  = 1'b1;
    model_fc = 0;
    start_one(64'h100);
    wait_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_frame_timeout: got none want one"); end
    es = model_frame_step();
`ifdef SERPENTINE_EN
    p8 = 15;
`else
    p8 = 8;
`endif
    checks++; if (mon_pix[p8] !== ALIVE) begin errors++; $display("FAIL rst_cell8: pixel %0d got %h want %h", p8, mon_pix[p8], ALIVE); end
    checks++; if (count_bad(64'h100) != 0) begin errors++; $display("FAIL rst_pixels: got %0d bad want 0", count_bad(64'h100)); end
    checks++; if (mon_nbits != 1536) begin errors++; $display("FAIL rst_bits: got %0d want 1536", mon_nbits); end
    checks++; if (mon_step_at_fd !== es) begin errors++; $display("FAIL rst_counter_cleared: got %b want %b", mon_step_at_fd, es); end
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.grid   = '0;
    test_reset();
    test_zero_frame();
    test_single_cell();
    test_random_frames();
    test_step();
    test_no_tearing();
    test_enable_drop();
    test_reset_mid();
    checks++; if (mon_stray != 0) begin errors++; $display("FAIL stray_step: got %0d want 0", mon_stray); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_frame_driver.md
Name: led_frame_driver

Overview:
- Downstream consumer of the Life rules stage. It snapshots the 64-bit grid, then serialises it as a WS2812B bit stream to an 8x8 LED matrix.
- After a configurable number of displayed frames it emits the one-cycle `step` pulse that advances the rules stage.
- It sits between the rules stage and the `dout` pin.

Parameters:
- T0H_CYC, 4: high time of a '0' bit, in clk cycles (~333 ns at 12 MHz).
- T1H_CYC, 8: high time of a '1' bit, in cycles.
- TBIT_CYC, 15: total bit period, in cycles. Must satisfy T0H_CYC < T1H_CYC < TBIT_CYC.
- LATCH_CYC, 600: low time after the last bit, in cycles (≥50 us). Must be ≥1.
- FRAMES_PER_STEP, 30: frames displayed per `step` pulse. Must be ≥1.
- ALIVE_GRB, 24'h001000: colour sent for a live cell, GRB order.
- DEAD_GRB, 24'h000000: colour sent for a dead cell.

Ports:
- `clk`  in  1: system clock.
- `reset_n`  in  1: asynchronous active-low reset.
- `enable`  in  1: level; permits starting new frames.
- `grid`  in  64: current Life state, bit index = row*8+col.
- `dout`  out  1: WS2812B serial data, registered.
- `step`  out  1: one-cycle pulse to the rules stage.
- `busy`  out  1: high while in SHIFT or LATCH.
- `frame_done`  out  1: one-cycle pulse at the end of each latch period.

Behaviour:
- Reset (async assert, sync release): state=IDLE. `dout`=0, `step`=0, `busy`=0, `frame_done`=0. Frame counter=0, snapshot=0.
- FSM states: IDLE, SHIFT, LATCH.
- IDLE:
  - On a clock edge with `enable`=1: capture `grid` into the snapshot register, pixel=0, bit=23, cycle=0, go to SHIFT.
  - `dout` rises at that same edge, so latency from `enable` sampled to the first high `dout` is 1 edge.
- SHIFT:
  - Pixel colour = ALIVE_GRB if its snapshot bit is 1, else DEAD_GRB. Bits are sent MSB first (bit 23 down to 0).
  - Within a bit, `dout`=1 for cycles 0..TH-1 and 0 for cycles TH..TBIT_CYC-1. TH is T1H_CYC if the bit is 1, else T0H_CYC.
  - After bit 0 of a pixel, advance pixel by 1. Pixel order is snapshot index 0..63.
  - After pixel 63 bit 0 completes (1536 bits, 1536*TBIT_CYC cycles), go to LATCH with `dout`=0.
- LATCH:
  - `dout`=0 for exactly LATCH_CYC cycles.
  - Final cycle: `frame_done`=1 and the frame counter increments.
  - If the counter reaches FRAMES_PER_STEP, `step`=1 in the same cycle and the counter clears to 0.
  - Then go to IDLE.
- IDLE minimum dwell is one cycle. This guarantees the rules stage has registered the new grid before the next snapshot.
- The snapshot is never updated during SHIFT or LATCH. `grid` changes mid-frame have no effect (no tearing).
- `enable` deasserted mid-frame: the current frame, including LATCH and any due `step`, completes. The block then stays in IDLE. While disabled, no `step` pulses occur and the frame counter holds.
- `busy` = (state != IDLE), registered with the state.
- Reset mid-frame: `dout` drops to 0 immediately (async). The partial frame is abandoned and the counter clears. After release, the next frame starts from pixel 0.
- Counter widths: the pixel counter is 6 bits (wraps at 63→done), the bit counter 5 bits, and the cycle counter `$clog2(max(TBIT_CYC, LATCH_CYC))` bits. Width of the frame counter is `$clog2(FRAMES_PER_STEP+1)`.

Optional Feature:
- Macro: SERPENTINE_EN.
- Defined: the matrix is serpentine-wired. Odd rows (1,3,5,7) are sent in column order 7..0; even rows in column order 0..7.
- Undefined: plain raster order, pixel p maps to snapshot bit p.
- The macro affects only the pixel→grid index mapping. Frame length and timing are unchanged.

Decomposition:
- Package `led_pkg`: state enum (IDLE, SHIFT, LATCH), `GRB_W`=24, `NUM_PIX`=64, `BITS_PER_FRAME`=1536, default timing constants.
- Sub-module `ws2812_bit_tx`: inputs `clk`, `reset_n`, `start`, `bit_val`; outputs `dout`, `bit_done`. It owns the per-bit cycle counter and high/low timing.
- The top level owns the FSM, snapshot, pixel/bit indices and step/frame counters.

Test Plan:
- Reset then `enable`=1, `grid`=64'h0: 1536 bits each high for 4 cycles, then 600 low cycles. `frame_done` pulses at cycle 1536*15+600 = 23640 after start.
- `grid`=64'h1 (cell 0 alive): bits 11 and 23..12 pattern checked. Pixel 0 decodes 24'h001000 (bit 12 high 8 cycles, others 4). Pixels 1..63 decode 0.
- FRAMES_PER_STEP=2, `enable` held: `step` pulses together with every 2nd `frame_done`, exactly 1 cycle wide. Check the snapshot of frame 3 equals the post-step grid.
- Change `grid` mid-SHIFT (0→all ones at pixel 10): the decoded frame is all DEAD_GRB. The next frame is all ALIVE_GRB.
- Drop `enable` at pixel 30: the frame completes with LATCH. `busy` falls, and no further `dout` activity or `step` occurs for 50000 cycles.
- Assert `reset_n`=0 at pixel 40 (async, mid-cycle): `dout`=0, `busy`=0, `step`=0 immediately. After release, the first pixel sent is pixel 0. With SERPENTINE_EN and only cell 8 (row 1, col 0) alive, pixel 15 decodes ALIVE_GRB.
